// File: rtl/rx_sipo_frame_pkg.sv
// Shared serial-port constants and the receive FSM state encoding.
// The transmit side and the start-bit FSM import this package as well.
package rx_sipo_frame_pkg;

    localparam int unsigned SAMPLES_PER_BIT  = 16;
    localparam int unsigned DEF_SAMPLE_POINT = 7;
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned FRAME_BITS       = DEF_DATA_BITS + 2;
    localparam logic        DEF_START_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone
    } rx_state_e;

endpackage

// File: rtl/rx_bit_counter.sv
// Bit sample counter (BSC) and bit identification counter (BIC), both cleared
// while enable is low, plus a strobe marking the mid-bit sample point.
module rx_bit_counter #(
    parameter int unsigned SAMPLE_POINT = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [3:0] BSC,
    output logic [3:0] BIC,
    output logic       sampleStrobe
);

    logic [3:0] bsc_q, bsc_d;
    logic [3:0] bic_q, bic_d;

    always_comb begin
        bsc_d = '0;
        bic_d = '0;
        if (enable) begin
            bsc_d = bsc_q + 4'd1;
            bic_d = bic_q;
            // BIC saturates so a late enable release never wraps the bit index
            if (bsc_q == 4'd15 && bic_q != 4'd15) begin
                bic_d = bic_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bsc_q <= '0;
            bic_q <= '0;
        end else begin
            bsc_q <= bsc_d;
            bic_q <= bic_d;
        end
    end

    assign BSC          = bsc_q;
    assign BIC          = bic_q;
    assign sampleStrobe = enable && (bsc_q == 4'(SAMPLE_POINT));

endmodule

// File: rtl/rx_sipo_frame.sv
// Receive datapath: mid-bit sampling, serial-to-parallel framing and a
// valid/acknowledge handshake with framing-error and sticky overrun status.
module rx_sipo_frame
    import rx_sipo_frame_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned SAMPLE_POINT = DEF_SAMPLE_POINT,
    parameter logic        START_LEVEL  = DEF_START_LEVEL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 bitStream,
    input  logic                 rdAck,
    output logic [3:0]           BSC,
    output logic [3:0]           BIC,
    output logic [DATA_BITS-1:0] data,
    output logic                 dataValid,
    output logic                 frameErr,
    output logic                 overrun
);

    localparam logic [3:0] StopBic = 4'(DATA_BITS + 1);

    logic                 sample_strobe;
    logic                 frame_done;
    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 false_start_q, false_start_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    rx_bit_counter #(
        .SAMPLE_POINT(SAMPLE_POINT)
    ) u_bit_counter (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .BSC         (BSC),
        .BIC         (BIC),
        .sampleStrobe(sample_strobe)
    );

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        false_start_d = false_start_q;
        data_d        = data_q;
        valid_d       = valid_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q;
        frame_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (sample_strobe) begin
                    if (BIC == 4'd0) begin
                        if (bitStream != START_LEVEL) begin
                            false_start_d = 1'b1;
                        end
                    end else if (BIC == StopBic) begin
                        state_d    = StDone;
                        frame_done = !false_start_q;
                    end else begin
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (BIC == 4'(i + 1)) begin
                                shift_d[i] = bitStream;
                            end
                        end
                    end
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Dropping enable abandons any partial frame
        if (!enable) begin
            state_d       = StIdle;
            shift_d       = '0;
            false_start_d = 1'b0;
        end

        if (rdAck && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // A completing frame wins over a same-cycle acknowledge for dataValid
        if (frame_done) begin
            data_d      = shift_q;
            frame_err_d = (bitStream != ~START_LEVEL);
            valid_d     = 1'b1;
            if (valid_q && !rdAck) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            false_start_q <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            false_start_q <= false_start_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data      = data_q;
    assign dataValid = valid_q;
    assign frameErr  = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_sipo_frame.sv
// Self-checking bench for rx_sipo_frame: directed and randomized frames scored
// against a frame-level model of the receiver's delivered state.
module tb_rx_sipo_frame;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       bitStream;
    logic       rdAck;
    logic [3:0] BSC;
    logic [3:0] BIC;
    logic [7:0] data;
    logic       dataValid;
    logic       frameErr;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    // Frame-level model of what the processor side should see
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_err;
    logic       m_ovr;

    rx_sipo_frame dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bitStream(bitStream),
        .rdAck    (rdAck),
        .BSC      (BSC),
        .BIC      (BIC),
        .data     (data),
        .dataValid(dataValid),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"}, 32'(data), 32'(m_data));
        check({tag, "_valid"}, 32'(dataValid), 32'(m_valid));
        check({tag, "_ferr"}, 32'(frameErr), 32'(m_err));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    // Holds enable for 'hold' clocks while driving one frame at 16 clk/bit;
    // 'probe' picks the iteration at which the counters are compared.
    task automatic run_frame(input string tag, input logic [7:0] dbyte, input logic start_b,
                             input logic stop_b, input bit ack_at_stop, input int hold,
                             input int probe);
        logic [9:0] fr;
        logic       v151;
        logic       v152;
        logic       pv;
        int         k;
        fr   = {stop_b, dbyte, start_b};
        pv   = m_valid;
        v151 = 1'bx;
        v152 = 1'bx;
        enable = 1'b1;
        for (int n = 0; n < hold; n++) begin
            bitStream = (n / 16 < 10) ? fr[n / 16] : 1'b0;
            rdAck     = ack_at_stop && (n == 151);
            @(posedge clk);
            #1;
            if (n == 150) v151 = dataValid;
            if (n == 151) v152 = dataValid;
            if (n == probe) begin
                k = n + 1;
                check({tag, "_bsc_mid"}, 32'(BSC), 32'(k % 16));
                check({tag, "_bic_mid"}, 32'(BIC), 32'((k / 16 > 15) ? 15 : k / 16));
            end
        end
        rdAck     = 1'b0;
        enable    = 1'b0;
        bitStream = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_bsc_idle"}, 32'(BSC), 32'd0);
        check({tag, "_bic_idle"}, 32'(BIC), 32'd0);

        if (hold > 151) begin
            if (start_b === 1'b1) begin
                m_ovr   = (m_valid && !ack_at_stop) ? 1'b1 : (ack_at_stop ? 1'b0 : m_ovr);
                m_valid = 1'b1;
                m_data  = dbyte;
                m_err   = (stop_b !== 1'b0);
            end else if (ack_at_stop && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            check({tag, "_lat151"}, 32'(v151), 32'(pv));
            check({tag, "_lat152"}, 32'(v152), 32'(m_valid));
        end
        check_outputs(tag);
    endtask

    task automatic pulse_ack(input string tag);
        rdAck = 1'b1;
        @(posedge clk);
        #1;
        rdAck = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        reset     = 1'b1;
        enable    = 1'b0;
        bitStream = 1'b0;
        rdAck     = 1'b0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_ovr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_bsc", 32'(BSC), 32'd0);
        check("rst_bic", 32'(BIC), 32'd0);
        check_outputs("rst");

        // Clean frame, then acknowledge, then a stray acknowledge
        run_frame("clean", 8'hA5, 1'b1, 1'b0, 1'b0, 169, 40);
        pulse_ack("ack1");
        pulse_ack("ack_idle");

        // Stop bit at the start level
        run_frame("badstop", 8'h3C, 1'b1, 1'b1, 1'b0, 169, 100);
        pulse_ack("ack2");

        // Overrun from two unacknowledged frames
        run_frame("ovr_a", 8'h11, 1'b1, 1'b0, 1'b0, 169, 15);
        run_frame("ovr_b", 8'h22, 1'b1, 1'b0, 1'b0, 169, 160);
        pulse_ack("ack3");

        // False start: start sample at the stop level
        b0 = 8'($urandom);
        run_frame("fstart", b0, 1'b0, 1'b0, 1'b0, 169, 7);

        // Acknowledge on the same clk as the second frame's stop sample
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        run_frame("sim_a", b0, 1'b1, 1'b0, 1'b0, 169, 31);
        run_frame("sim_b", b1, 1'b1, 1'b0, 1'b1, 169, 152);

        // Randomized frames: occasional false starts, bad stops and acks
        for (int i = 0; i < 6; i++) begin
            run_frame("rand", 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                      1'($urandom), 169 + int'($urandom_range(0, 3)), int'($urandom_range(0, 168)));
        end

        // Abort at BIC=4: nothing delivered
        pulse_ack("ack4");
        run_frame("abort", 8'hFF, 1'b1, 1'b0, 1'b0, 16 * 4 + 5, 16 * 4 + 2);

        // Reset mid-frame at BIC=6 with a byte already held
        run_frame("pre_rst", 8'h5A, 1'b1, 1'b1, 1'b0, 169, 50);
        enable = 1'b1;
        for (int n = 0; n < 100; n++) begin
            bitStream = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("mid_bic", 32'(BIC), 32'd6);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        check("rst2_bsc", 32'(BSC), 32'd0);
        check("rst2_bic", 32'(BIC), 32'd0);
        check_outputs("rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
